// File: rtl/tick_scheduler.sv
// tick_scheduler: one free-running prescaler feeding NCH independent base-tick channels
// that emit one-cycle clock-enable pulses. Define TICK_IRQ_EN for sticky pending flags + irq.
module tick_sched_ch #(
    parameter int PW = 16
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    input  logic          base_tick,
    input  logic          start,
    input  logic          stop,
    input  logic          cfg_wr,
    input  logic [PW-1:0] cfg_period,
    input  logic          cfg_oneshot,
    output logic          tick,
    output logic          busy
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q;
    logic [PW-1:0] cnt_q;
    logic          tick_q;
    logic [PW-1:0] period_q, period_d;
    logic          oneshot_q, oneshot_d;

    always_comb begin
        period_d  = period_q;
        oneshot_d = oneshot_q;
        if (cfg_wr) begin
            period_d  = cfg_period;
            oneshot_d = cfg_oneshot;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            period_q  <= '0;
            oneshot_q <= 1'b0;
        end else begin
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
        end
    end

    // Stop beats start beats expiry; config is only sampled at start/reload.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (stop) begin
                state_q <= IDLE;
            end else if (start) begin
                if (period_q != '0) begin
                    state_q <= RUN;
                    cnt_q   <= period_q;
                end else begin
                    state_q <= IDLE;
                end
            end else if (state_q == RUN && base_tick) begin
                if (cnt_q == PW'(1)) begin
                    tick_q <= 1'b1;
                    if (oneshot_q || period_q == '0) state_q <= IDLE;
                    else                             cnt_q   <= period_q;
                end else begin
                    cnt_q <= cnt_q - PW'(1);
                end
            end
        end
    end

    assign tick = tick_q;
    assign busy = (state_q == RUN);
endmodule

module tick_scheduler #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BASE_HZ = 1000,
    parameter int NCH     = 4,
    parameter int PW      = 16,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_100MHz,
    input  logic           reset,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [PW-1:0]  cfg_period,
    input  logic           cfg_oneshot,
    input  logic [NCH-1:0] ch_start,
    input  logic [NCH-1:0] ch_stop,
    input  logic [NCH-1:0] irq_clr,
    output logic           base_tick,
    output logic [NCH-1:0] ch_tick,
    output logic [NCH-1:0] ch_busy,
    output logic           irq
);
    localparam int DIV = CLK_HZ / BASE_HZ;
    localparam int PSW = $clog2(DIV);

    logic [PSW-1:0] presc_q, presc_d;
    logic           base_tick_q, base_tick_d;
    logic [NCH-1:0] cfg_wr;

    always_comb begin
        base_tick_d = (presc_q == PSW'(DIV - 1));
        presc_d     = base_tick_d ? '0 : presc_q + PSW'(1);
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            base_tick_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            base_tick_q <= base_tick_d;
        end
    end

    assign base_tick = base_tick_q;

    // Out-of-range cfg_ch matches no channel, so the write is dropped.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign cfg_wr[k] = cfg_we && (int'(cfg_ch) == k);

        tick_sched_ch #(.PW(PW)) u_ch (
            .clk_100MHz  (clk_100MHz),
            .reset       (reset),
            .base_tick   (base_tick_q),
            .start       (ch_start[k]),
            .stop        (ch_stop[k]),
            .cfg_wr      (cfg_wr[k]),
            .cfg_period  (cfg_period),
            .cfg_oneshot (cfg_oneshot),
            .tick        (ch_tick[k]),
            .busy        (ch_busy[k])
        );
    end

`ifdef TICK_IRQ_EN
    logic [NCH-1:0] pending_q, pending_d;

    always_comb pending_d = (pending_q & ~irq_clr) | ch_tick;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign irq = |pending_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = ^irq_clr;
    assign irq            = 1'b0;
`endif
endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler (DIV=10, NCH=4): stimulus queues expected ch_tick
// events, a negedge monitor pops and compares them and checks base_tick every cycle.
module tb_tick_scheduler;
    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic        cfg_oneshot;
    logic [3:0]  ch_start, ch_stop, irq_clr;
    logic        base_tick;
    logic [3:0]  ch_tick, ch_busy;
    logic        irq;

`ifdef TICK_IRQ_EN
    localparam int IRQ_ON = 1;
`else
    localparam int IRQ_ON = 0;
`endif

    tick_scheduler #(.CLK_HZ(1000), .BASE_HZ(100), .NCH(4), .PW(16)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .ch_start    (ch_start),
        .ch_stop     (ch_stop),
        .irq_clr     (irq_clr),
        .base_tick   (base_tick),
        .ch_tick     (ch_tick),
        .ch_busy     (ch_busy),
        .irq         (irq)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct { int cyc; logic [3:0] tick; } exp_t;
    exp_t exp_q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk_100MHz or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: prescaler phase is known from reset release, ticks come from the queue.
    always @(negedge clk_100MHz) begin
        if (!reset) begin
            chk("base_tick", int'(base_tick), (cyc % 10 == 0 && cyc != 0) ? 1 : 0);
            if (IRQ_ON == 0) chk("irq_tied0", int'(irq), 0);
            if (ch_tick != 4'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tick", int'(ch_tick), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("tick_cycle", cyc, e.cyc);
                    chk("tick_vec", int'(ch_tick), int'(e.tick));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk_100MHz);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic write_cfg(input int ch, input int p, input bit os);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = 16'(p); cfg_oneshot = os;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic start(input logic [3:0] m, output int s);
        s = cyc;
        ch_start = m;
        step();
        ch_start = 4'b0;
    endtask

    task automatic stop(input logic [3:0] m);
        ch_stop = m;
        step();
        ch_stop = 4'b0;
    endtask

    task automatic push(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c; e.tick = v;
        exp_q.push_back(e);
    endtask

    // Start sampled at edge s+1; first counted base tick is the next multiple of 10.
    function automatic int first_tick(input int s, input int p);
        return 10 * (s / 10 + p) + 1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, t, t1;
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_oneshot = 1'b0;
        ch_start = '0; ch_stop = '0; irq_clr = '0;
        repeat (3) @(posedge clk_100MHz);
        step();
        reset = 1'b0;

        // Idle: only base_tick activity.
        wait_cyc(40);
        chk("idle_busy", int'(ch_busy), 0);
        chk("idle_tick", int'(ch_tick), 0);

        // Periodic ch0, period 3: five ticks 30 clks apart.
        write_cfg(0, 3, 0);
        start(4'b0001, s);
        chk("p_busy_on", int'(ch_busy[0]), 1);
        t = first_tick(s, 3);
        for (int i = 0; i < 5; i++) push(t + 30 * i, 4'b0001);
        wait_cyc(t + 123);
        stop(4'b0001);
        chk("p_busy_off", int'(ch_busy[0]), 0);

        // One-shot ch1, period 2: busy drops with the single tick.
        write_cfg(1, 2, 1);
        start(4'b0010, s);
        t = first_tick(s, 2);
        push(t, 4'b0010);
        wait_cyc(t - 1);
        chk("os_busy_before", int'(ch_busy[1]), 1);
        step();
        chk("os_tick", int'(ch_tick[1]), 1);
        chk("os_busy_after", int'(ch_busy[1]), 0);
        wait_cyc(cyc + 40);
        chk("os_stays_idle", int'(ch_busy[1]), 0);

        // Zero period never runs; start+stop together leaves the channel idle.
        write_cfg(2, 0, 0);
        start(4'b0100, s);
        chk("zero_period_busy", int'(ch_busy[2]), 0);
        write_cfg(3, 1, 0);
        ch_start = 4'b1000; ch_stop = 4'b1000;
        step();
        ch_start = '0; ch_stop = '0;
        chk("start_stop_busy", int'(ch_busy[3]), 0);
        wait_cyc(cyc + 30);

        // Simultaneous expiry on ch0 and ch3.
        write_cfg(0, 2, 0);
        write_cfg(3, 2, 0);
        start(4'b1001, s);
        t = first_tick(s, 2);
        push(t, 4'b1001);
        wait_cyc(t + 2);
        stop(4'b1001);
        chk("sim_busy_off", int'(ch_busy), 0);

        // Stop landing on the expiry edge suppresses the tick.
        write_cfg(0, 3, 0);
        start(4'b0001, s);
        t = first_tick(s, 3);
        wait_cyc(t - 1);
        stop(4'b0001);
        chk("stop_at_expiry_busy", int'(ch_busy[0]), 0);
        wait_cyc(cyc + 5);

        // Period rewritten mid-run takes effect at the reload.
        start(4'b0001, s);
        write_cfg(0, 5, 0);
        t = first_tick(s, 3);
        push(t, 4'b0001); push(t + 50, 4'b0001); push(t + 100, 4'b0001);
        wait_cyc(t + 103);
        stop(4'b0001);

        // Pending flags: clear backlog, then set-wins-over-clear, then clear alone.
        irq_clr = 4'hF;
        step();
        irq_clr = '0;
        chk("irq_cleared", int'(irq), 0);
        write_cfg(0, 1, 0);
        start(4'b0001, s);
        t = first_tick(s, 1);
        push(t, 4'b0001); push(t + 10, 4'b0001);
        wait_cyc(t);
        chk("irq_before", int'(irq), 0);
        step();
        chk("irq_set", int'(irq), IRQ_ON);
        wait_cyc(t + 10);
        irq_clr = 4'b0001;
        step();
        irq_clr = '0;
        chk("irq_set_wins", int'(irq), IRQ_ON);
        stop(4'b0001);
        irq_clr = 4'b0001;
        step();
        irq_clr = '0;
        chk("irq_clr_alone", int'(irq), 0);

        // Reset mid-run clears outputs at once and wipes config.
        write_cfg(0, 2, 0);
        write_cfg(1, 1, 0);
        start(4'b0011, s);
        t1 = first_tick(s, 1);
        push(t1, 4'b0010);
        push(t1 + 10, 4'b0011);
        wait_cyc(t1 + 10);
        #2 reset = 1'b1;
        #1;
        chk("rst_tick", int'(ch_tick), 0);
        chk("rst_busy", int'(ch_busy), 0);
        chk("rst_base", int'(base_tick), 0);
        chk("rst_irq", int'(irq), 0);
        repeat (2) @(posedge clk_100MHz);
        step();
        reset = 1'b0;
        start(4'b0001, s);
        chk("rst_cfg_cleared", int'(ch_busy[0]), 0);
        wait_cyc(cyc + 40);

        chk("exp_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
